// File: rtl/issue_hazard_unit_if.sv
// Fetch/issue bundle of the issue hazard unit. The unit itself is the slave;
// the fetch side and the core side together form the master.
interface issue_hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      fetch_instr;
    logic             fetch_valid;
    logic             fetch_ready;
    logic             flush;
    logic [31:0]      issue_instr;
    logic             stall;
    logic [CNT_W-1:0] bubble_count;

    modport slave (
        input  fetch_instr,
        input  fetch_valid,
        input  flush,
        output fetch_ready,
        output issue_instr,
        output stall,
        output bubble_count
    );

    modport master (
        output fetch_instr,
        output fetch_valid,
        output flush,
        input  fetch_ready,
        input  issue_instr,
        input  stall,
        input  bubble_count
    );
endinterface

// File: rtl/issue_hazard_unit.sv
// Issue stage: holds one fetched instruction, checks its register and flag
// dependencies against the last DEPTH issued slots and inserts NOP bubbles
// (32'h0) until they clear. Fetch is back-pressured while a bubble is issued.
module issue_hazard_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    issue_hazard_unit_if.slave bus
);
    typedef struct packed {
        logic       wr_valid;
        logic [3:0] wr_reg;
        logic       sets_flags;
    } sb_entry_t;

    logic                  pend_valid_q;
    logic [31:0]           pend_instr_q;
    sb_entry_t [DEPTH-1:0] sb_q;
    logic [31:0]           issue_q;
    logic                  stall_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [2:0]            src_vld;
    logic [2:0][3:0]       src_reg;
    logic                  reads_flags;
    sb_entry_t             dec_entry;
    logic                  hazard;
    logic                  fetch_ready;
    logic                  do_issue;
    logic                  do_bubble;

    // Decode the pending instruction and compare it against the scoreboard.
    always_comb begin
        logic [1:0] op;
        logic [3:0] cmd;
        logic       imm;
        logic       sl;
        op          = pend_instr_q[27:26];
        cmd         = pend_instr_q[24:21];
        imm         = pend_instr_q[25];
        sl          = pend_instr_q[20];
        src_reg[0]  = pend_instr_q[19:16];   // rn
        src_reg[1]  = pend_instr_q[3:0];     // rm
        src_reg[2]  = pend_instr_q[15:12];   // rd (store data)
        src_vld     = '0;
        dec_entry   = '0;
        reads_flags = (pend_instr_q[31:28] != 4'hE);
        hazard      = 1'b0;
        case (op)
            2'b00: begin
                src_vld[0] = !(cmd == 4'b1101 || cmd == 4'b1111);
                src_vld[1] = !imm;
                dec_entry.wr_valid   = (cmd[3:2] != 2'b10);
                dec_entry.sets_flags = sl;
            end
            2'b01: begin
                src_vld[0] = 1'b1;
                src_vld[1] = imm;
                src_vld[2] = !sl;
                dec_entry.wr_valid = sl;
            end
            default: ;
        endcase
        dec_entry.wr_reg = pend_instr_q[15:12];
        // PC reads are always current, so R15 never creates a dependency.
        for (int s = 0; s < 3; s++) begin
            if (src_reg[s] == 4'd15) src_vld[s] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 3; s++) begin
                if (src_vld[s] && sb_q[i].wr_valid && sb_q[i].wr_reg == src_reg[s])
                    hazard = 1'b1;
            end
            if (reads_flags && sb_q[i].sets_flags) hazard = 1'b1;
        end
        hazard = hazard && pend_valid_q;
    end

    assign fetch_ready = reset && (!pend_valid_q || !hazard);
    // A flush turns the current slot into an uncounted idle slot.
    assign do_issue    = pend_valid_q && !hazard && !bus.flush;
    assign do_bubble   = pend_valid_q &&  hazard && !bus.flush;

    // Pending register: flush wins over a fetch arriving in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid_q <= 1'b0;
            pend_instr_q <= '0;
        end else if (bus.flush) begin
            pend_valid_q <= 1'b0;
        end else if (bus.fetch_valid && fetch_ready) begin
            pend_valid_q <= 1'b1;
            pend_instr_q <= bus.fetch_instr;
        end else if (do_issue) begin
            pend_valid_q <= 1'b0;
        end
    end

    // Issue slot, scoreboard shift and saturating bubble counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q    <= '0;
            issue_q <= '0;
            stall_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sb_q    <= {sb_q[DEPTH-2:0], (do_issue ? dec_entry : sb_entry_t'('0))};
            issue_q <= do_issue ? pend_instr_q : 32'h0;
            stall_q <= do_bubble;
            if (do_bubble && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.fetch_ready  = fetch_ready;
    assign bus.issue_instr  = issue_q;
    assign bus.stall        = stall_q;
    assign bus.bubble_count = cnt_q;
endmodule
